mem_arbiter: RTL and testbench

- Shares the single external memory bus between the instruction-fetch port and the data port driven by the execute/memory stages (load/store with size and sign-extend controls).
- Arbitrates between the two ports, generates byte enables, and replicates store data.
- Aligns and extends load data, detects misalignment, and enforces a bus timeout.
- Holds one transaction at a time. Requesters stall on their own port until `done`.

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between the instruction-fetch
// port (i_*) and the load/store data port (d_*). Only one transfer is in
// flight at a time.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   i_req/i_addr   fetch request (word access), held until i_done
//   i_rdata/i_done/i_err   fetch response, valid for the single i_done cycle
//   d_req/d_we/d_addr/d_sz/d_sx/d_wdata   data request, held until d_done
//   d_rdata/d_done/d_err   data response, valid for the single d_done cycle
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   bus command, driven while BUSY
//   bus_rdata/bus_ack      bus response, sampled only while BUSY
//   dbg_state      current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake: a requester raises its req and holds it with stable attributes
// until its done pulse. The arbiter samples requests only in IDLE. The done
// pulse lasts one cycle. A req still high in the following IDLE cycle counts
// as a new request. bus_ack completes a bus cycle only while bus_req is high.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_sz,
    input  logic        d_sx,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // Timeout fires on the cycle that would bring the wait count to TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        last_grant;
    logic        owner;
    logic        we_q;
    logic        sx_q;
    logic [1:0]  sz_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  cnt;

    // Grant selection for the IDLE cycle.
    logic        grant_sel;
    logic [31:0] g_addr;
    logic [1:0]  g_sz;
    logic        g_mis;

    always_comb begin
        grant_sel = OWN_FETCH;
        if (i_req && d_req) begin
            // Tie: alternate away from the last owner.
            grant_sel = (last_grant == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end else if (d_req) begin
            grant_sel = OWN_DATA;
        end
        g_addr = (grant_sel == OWN_DATA) ? d_addr : i_addr;
        // Fetches are treated as word accesses throughout.
        g_sz   = (grant_sel == OWN_DATA) ? d_sz : 2'd2;
        case (g_sz)
            2'd0:    g_mis = 1'b0;
            2'd1:    g_mis = g_addr[0];
            2'd2:    g_mis = |g_addr[1:0];
            default: g_mis = 1'b1;
        endcase
    end

    // Lane steering from the latched request.
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    assign shifted = bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (sz_q)
            2'd0: begin
                load_data = {{24{sx_q & shifted[7]}}, shifted[7:0]};
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                load_data = {{16{sx_q & shifted[15]}}, shifted[15:0]};
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                load_data = shifted;
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= OWN_FETCH;
            owner      <= OWN_FETCH;
            we_q       <= 1'b0;
            sx_q       <= 1'b0;
            sz_q       <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            cnt        <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        we_q       <= (grant_sel == OWN_DATA) ? d_we : 1'b0;
                        sx_q       <= (grant_sel == OWN_DATA) ? d_sx : 1'b0;
                        wdata_q    <= (grant_sel == OWN_DATA) ? d_wdata : 32'd0;
                        addr_q     <= g_addr;
                        sz_q       <= g_sz;
                        cnt        <= 8'd0;
                        if (g_mis) begin
                            // Misaligned: answer straight away, no bus cycle.
                            rdata_q <= 32'd0;
                            err_q   <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // An ack on the timeout cycle still completes normally.
                    if (bus_ack) begin
                        rdata_q <= load_data;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (cnt == TO_LAST) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                        cnt     <= cnt + 8'd1;
                        state   <= S_RESP;
                    end else begin
                        cnt     <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    // Bus outputs are forced to zero outside BUSY, so error transfers
    // show bus_be=0 and no bus_req.
    assign bus_req   = (state == S_BUSY);
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? be : 4'd0;
    assign bus_wdata = bus_req ? wdata_rep : 32'd0;

    assign i_done  = (state == S_RESP) && (owner == OWN_FETCH);
    assign d_done  = (state == S_RESP) && (owner == OWN_DATA);
    assign i_rdata = i_done ? rdata_q : 32'd0;
    assign d_rdata = d_done ? rdata_q : 32'd0;
    assign i_err   = i_done & err_q;
    assign d_err   = d_done & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven single transfers, then tie
// alternation, bus timeout, ack on the timeout cycle and reset mid-transfer.
// Responses are checked against an expected queue when a done pulse appears.
module tb_mem_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_sz;
    logic        d_sx;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [1:0]  dbg_state;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sz(d_sz), .d_sx(d_sx),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // Entry: {is_fetch, err, rdata}
    logic [33:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    logic [33:0] mon_e;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst && (i_done || d_done)) begin
            chk("done_exclusive", {31'd0, i_done & d_done}, 32'd0);
            chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_port", {31'd0, i_done}, {31'd0, mon_e[33]});
                chk("rdata", mon_e[33] ? i_rdata : d_rdata, mon_e[31:0]);
                chk("err", {31'd0, mon_e[33] ? i_err : d_err}, {31'd0, mon_e[32]});
            end
        end
        prev_done = i_done | d_done;
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] wdata;
        logic [31:0] brdata;
        logic        exp_bus;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic f, input logic we, input logic [31:0] a,
                                input logic [1:0] sz, input logic sx, input logic [31:0] wd,
                                input logic [31:0] brd, input logic eb, input logic [3:0] ebe,
                                input logic [31:0] ebw, input logic [31:0] erd, input logic ee);
        vec_t v;
        v.fetch = f; v.we = we; v.addr = a; v.sz = sz; v.sx = sx; v.wdata = wd;
        v.brdata = brd; v.exp_bus = eb; v.exp_be = ebe; v.exp_bwdata = ebw;
        v.exp_rdata = erd; v.exp_err = ee;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_sz = 2'd0; d_sx = 1'b0; d_wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit seen_bus;
        bit got;
        int lat;
        seen_bus = 1'b0;
        got = 1'b0;
        lat = 0;
        exp_q.push_back({v.fetch, v.exp_err, v.exp_rdata});
        @(posedge clk); #1;
        if (v.fetch) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_sz = v.sz; d_sx = v.sx;
            d_wdata = v.wdata;
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req && !seen_bus) begin
                seen_bus = 1'b1;
                chk($sformatf("v%0d_bus_latency", idx), n, 2);
                chk($sformatf("v%0d_bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d_bus_be", idx), {28'd0, bus_be}, {28'd0, v.exp_be});
                chk($sformatf("v%0d_bus_we", idx), {31'd0, bus_we}, {31'd0, v.we});
                if (v.we) chk($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.exp_bwdata);
                bus_ack = 1'b1;
                bus_rdata = v.brdata;
            end else if (bus_req) begin
                seen_bus = 1'b1;
            end
            if (v.fetch ? i_done : d_done) begin
                got = 1'b1;
                lat = n;
                i_req = 1'b0;
                d_req = 1'b0;
                break;
            end
        end
        bus_ack = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), {31'd0, got}, 32'd1);
        chk($sformatf("v%0d_done_latency", idx), lat, v.exp_bus ? 3 : 2);
        chk($sformatf("v%0d_bus_used", idx), {31'd0, seen_bus}, {31'd0, v.exp_bus});
    endtask

    // Word load at 0x30 that waits for a late ack (ack_at bus cycles) or
    // never gets one (ack_at = 0).
    task automatic run_timeout(input int ack_at, input logic [31:0] rd);
        int nbus;
        bit got;
        nbus = 0;
        got = 1'b0;
        exp_q.push_back({1'b0, (ack_at == 0), (ack_at == 0) ? 32'd0 : rd});
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; d_sz = 2'd2; d_sx = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req) begin
                nbus++;
                if (nbus == ack_at) begin
                    bus_ack = 1'b1;
                    bus_rdata = rd;
                end
            end
            if (d_done) begin
                got = 1'b1;
                d_req = 1'b0;
                break;
            end
        end
        bus_ack = 1'b0;
        chk("timeout_done_seen", {31'd0, got}, 32'd1);
        chk("timeout_bus_cycles", nbus, (ack_at == 0) ? TIMEOUT : ack_at);
    endtask

    task automatic wait_bus(input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (i_done || d_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int ndone;
        //                fetch we  addr          sz   sx  wdata          brdata         bus  be       bwdata         rdata          err
        vecs[0]  = mk(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h203, 2'd0, 1'b1, 32'h0,        32'h80112233, 1'b1, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h203, 2'd0, 1'b0, 32'h0,        32'h80112233, 1'b1, 4'b1000, 32'h0,        32'h00000080, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 32'h12,  2'd1, 1'b0, 32'h0000ABCD, 32'h0,        1'b1, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h06,  2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 32'h02,  2'd1, 1'b1, 32'h0,        32'h80011234, 1'b1, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h01,  2'd0, 1'b0, 32'h0,        32'h0000F500, 1'b1, 4'b0010, 32'h0,        32'h000000F5, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 32'h01,  2'd0, 1'b0, 32'h123456A5, 32'h0,        1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 32'h20,  2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 32'h01,  2'd1, 1'b0, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1);
        vecs[10] = mk(1'b0, 1'b0, 32'h00,  2'd3, 1'b0, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1);
        vecs[11] = mk(1'b1, 1'b0, 32'h102, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1);
        vecs[12] = mk(1'b0, 1'b0, 32'h44,  2'd2, 1'b0, 32'h0,        32'h89ABCDEF, 1'b1, 4'b1111, 32'h0,        32'h89ABCDEF, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 32'h200, 2'd0, 1'b1, 32'h0,        32'h0000007F, 1'b1, 4'b0001, 32'h0,        32'h0000007F, 1'b0);

        // Reset state.
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {23'd0, bus_req, bus_we, bus_be, i_done, i_err, d_done}, 32'd0);
        chk("reset_d_err", {31'd0, d_err}, 32'd0);
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_bus_wdata", bus_wdata, 32'd0);
        chk("reset_i_rdata", i_rdata, 32'd0);
        chk("reset_d_rdata", d_rdata, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
            if ($urandom_range(1, 0) == 1) @(posedge clk);
        end

        // Tie alternation: both ports requesting since reset; data wins first.
        @(posedge clk); #1;
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_sz = 2'd2; d_sx = 1'b0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back({(k % 2 == 1), 1'b0, 32'h1000 + 32'(k)});
        @(posedge clk); #1;
        chk("tie_reset_bus_req", {31'd0, bus_req}, 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_bus($sformatf("tie%0d_bus_seen", k));
            chk($sformatf("tie%0d_owner_addr", k), bus_addr, (k % 2 == 0) ? 32'h80 : 32'h40);
            bus_ack = 1'b1;
            bus_rdata = 32'h1000 + 32'(k);
            wait_done($sformatf("tie%0d_done_seen", k));
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // Timeout with no ack, then an ack on the final allowed cycle.
        run_timeout(0, 32'h0);
        run_timeout(TIMEOUT, 32'h5555AAAA);

        // Reset asserted during BUSY: bus drops at once, no response follows.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50; d_sz = 2'd2; d_sx = 1'b0;
        wait_bus("rstmid_bus_seen");
        rst = 1'b0;
        #1;
        chk("rstmid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rstmid_state", {30'd0, dbg_state}, 32'd0);
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (i_done || d_done || bus_req) ndone++;
        end
        chk("rstmid_no_activity", ndone, 0);

        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
